// File: rtl/wb_dest_tracker.sv
// Write-back destination tracker.
// Picks the destination register of each issuing instruction from one of five
// sources, queues accepted destinations in order for write-back, and keeps a
// per-register pending scoreboard for RAW/WAW hazard stalls.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-low reset
//   dst_sel           source select: 000 instr_rd, 001 rt, 010 LINK_REG,
//                     011 SP_REG, 100 rs, 101-111 reserved
//   instr_rd, rt, rs  candidate destination fields
//   issue_valid       issuing instruction wants to reserve a destination
//   issue_ready       destination can be accepted this cycle (combinational)
//   wb_valid, wb_addr FIFO head destination awaiting write-back
//   wb_ready          write-back consumes the head this cycle
//   chk_addr          address to hazard-check
//   chk_busy          pending[chk_addr] (combinational)
//   pending           scoreboard, bit 0 always 0
//   count             FIFO occupancy
//   sel_err           sticky flag: issue attempted with reserved select
module wb_dest_tracker #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned LINK_REG = 31,
   parameter int unsigned SP_REG   = 29
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   dst_sel,
   input  logic [ADDR_W-1:0]            instr_rd,
   input  logic [ADDR_W-1:0]            rt,
   input  logic [ADDR_W-1:0]            rs,
   input  logic                         issue_valid,
   output logic                         issue_ready,
   output logic                         wb_valid,
   output logic [ADDR_W-1:0]            wb_addr,
   input  logic                         wb_ready,
   input  logic [ADDR_W-1:0]            chk_addr,
   output logic                         chk_busy,
   output logic [(2**ADDR_W)-1:0]       pending,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         sel_err
);

   localparam int unsigned NREG  = 2**ADDR_W;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] fifo_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [NREG-1:0]   pending_d;
   logic [ADDR_W-1:0] dest;
   logic [ADDR_W-1:0] head;
   logic              legal;
   logic              issue_fire;
   logic              pop_fire;

   // Destination source mux; reserved selects yield dest 0 and are illegal.
   always_comb begin
      dest  = '0;
      legal = 1'b0;
      case (dst_sel)
         3'b000: begin dest = instr_rd;           legal = 1'b1; end
         3'b001: begin dest = rt;                 legal = 1'b1; end
         3'b010: begin dest = ADDR_W'(LINK_REG);  legal = 1'b1; end
         3'b011: begin dest = ADDR_W'(SP_REG);    legal = 1'b1; end
         3'b100: begin dest = rs;                 legal = 1'b1; end
         default: begin dest = '0;                legal = 1'b0; end
      endcase
   end

   // Accept only when there is room and no outstanding write to the same
   // non-zero register; a same-cycle pop does not bypass either condition.
   always_comb begin
      issue_ready = legal && (count < CNT_W'(DEPTH)) &&
                    ((dest == '0) || !pending[dest]);
      issue_fire  = issue_valid && issue_ready;
      pop_fire    = wb_valid && wb_ready;
      head        = fifo_q[rd_ptr];
      wb_valid    = (count != '0);
      wb_addr     = wb_valid ? head : '0;
      chk_busy    = pending[chk_addr];
   end

   // Scoreboard update; head and dest can never coincide when both fire.
   always_comb begin
      pending_d = pending;
      if (pop_fire && (head != '0))
         pending_d[head] = 1'b0;
      if (issue_fire && (dest != '0))
         pending_d[dest] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // FIFO storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (issue_fire)
         fifo_q[wr_ptr] <= dest;
   end

   // Pointers, occupancy, scoreboard and sticky error.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         pending <= '0;
         sel_err <= 1'b0;
      end else begin
         if (issue_fire)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_fire)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (issue_fire && !pop_fire)
            count <= count + CNT_W'(1);
         else if (pop_fire && !issue_fire)
            count <= count - CNT_W'(1);
         pending <= pending_d;
         if (issue_valid && !legal)
            sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Directed testbench for wb_dest_tracker (default parameters).
module tb_wb_dest_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  dst_sel;
   logic [4:0]  instr_rd;
   logic [4:0]  rt;
   logic [4:0]  rs;
   logic        issue_valid;
   logic        issue_ready;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        wb_ready;
   logic [4:0]  chk_addr;
   logic        chk_busy;
   logic [31:0] pending;
   logic [2:0]  count;
   logic        sel_err;

   int n_checks = 0;
   int n_fail   = 0;

   wb_dest_tracker dut (
      .clk(clk), .reset(reset), .dst_sel(dst_sel), .instr_rd(instr_rd),
      .rt(rt), .rs(rs), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
      .chk_addr(chk_addr), .chk_busy(chk_busy), .pending(pending),
      .count(count), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] sel, input logic [4:0] rd_v,
                        input logic [4:0] rt_v, input logic [4:0] rs_v);
      dst_sel = sel; instr_rd = rd_v; rt = rt_v; rs = rs_v;
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; dst_sel = 3'b000; instr_rd = 5'd0; rt = 5'd0; rs = 5'd0;
      issue_valid = 1'b0; wb_ready = 1'b0; chk_addr = 5'd0;
      tick(); tick();
      reset = 1'b1;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
      n_checks++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wb_addr: got %0d expected 0", wb_addr); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", pending); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
   endtask

   task automatic test_basic();
      dst_sel = 3'b000; instr_rd = 5'd8;
      #1;
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b expected 1", issue_ready); end
      issue(3'b000, 5'd8, 5'd0, 5'd0);
      chk_addr = 5'd8;
      #1;
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL basic_wb_valid: got %b expected 1", wb_valid); end
      n_checks++; if (wb_addr !== 5'd8) begin n_fail++; $display("FAIL basic_wb_addr: got %0d expected 8", wb_addr); end
      n_checks++; if (pending !== 32'h0000_0100) begin n_fail++; $display("FAIL basic_pending: got %h expected 00000100", pending); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", count); end
      n_checks++; if (chk_busy !== 1'b1) begin n_fail++; $display("FAIL basic_chk_busy: got %b expected 1", chk_busy); end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      #1;
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_wb_valid: got %b expected 0", wb_valid); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL basic_pop_pending: got %h expected 0", pending); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL basic_pop_count: got %0d expected 0", count); end
      n_checks++; if (chk_busy !== 1'b0) begin n_fail++; $display("FAIL basic_pop_chk_busy: got %b expected 0", chk_busy); end
   endtask

   task automatic test_sources();
      logic [4:0] exp_q [4] = '{5'd9, 5'd31, 5'd29, 5'd4};
      issue(3'b001, 5'd0, 5'd9, 5'd0);
      issue(3'b010, 5'd0, 5'd0, 5'd0);
      issue(3'b011, 5'd0, 5'd0, 5'd0);
      issue(3'b100, 5'd0, 5'd0, 5'd4);
      dst_sel = 3'b000; instr_rd = 5'd3;
      #1;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL src_count: got %0d expected 4", count); end
      n_checks++; if (pending !== 32'hA000_0210) begin n_fail++; $display("FAIL src_pending: got %h expected a0000210", pending); end
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL src_full_ready: got %b expected 0", issue_ready); end
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (wb_addr !== exp_q[i]) begin n_fail++; $display("FAIL src_drain_%0d: got %0d expected %0d", i, wb_addr, exp_q[i]); end
         tick();
      end
      wb_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL src_drained_count: got %0d expected 0", count); end
   endtask

   task automatic test_hazard();
      issue(3'b000, 5'd12, 5'd0, 5'd0);
      dst_sel = 3'b000; instr_rd = 5'd12; issue_valid = 1'b1; chk_addr = 5'd12;
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL haz_ready: got %b expected 0", issue_ready); end
      n_checks++; if (chk_busy !== 1'b1) begin n_fail++; $display("FAIL haz_chk_busy: got %b expected 1", chk_busy); end
      wb_ready = 1'b1;
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL haz_pop_ready: got %b expected 0", issue_ready); end
      tick();
      wb_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL haz_pop_count: got %0d expected 0", count); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL haz_next_ready: got %b expected 1", issue_ready); end
      tick();
      issue_valid = 1'b0;
      #1;
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL haz_reissue_count: got %0d expected 1", count); end
      n_checks++; if (wb_addr !== 5'd12) begin n_fail++; $display("FAIL haz_reissue_addr: got %0d expected 12", wb_addr); end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
   endtask

   task automatic test_zero();
      issue(3'b000, 5'd0, 5'd0, 5'd0);
      issue(3'b000, 5'd0, 5'd0, 5'd0);
      issue(3'b000, 5'd0, 5'd0, 5'd0);
      chk_addr = 5'd0;
      #1;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL zero_count: got %0d expected 3", count); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL zero_pending: got %h expected 0", pending); end
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL zero_wb_valid: got %b expected 1", wb_valid); end
      n_checks++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL zero_wb_addr: got %0d expected 0", wb_addr); end
      n_checks++; if (chk_busy !== 1'b0) begin n_fail++; $display("FAIL zero_chk_busy: got %b expected 0", chk_busy); end
      wb_ready = 1'b1;
      tick(); tick(); tick();
      wb_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL zero_drain_count: got %0d expected 0", count); end
   endtask

   task automatic test_full_wrap();
      logic [4:0] exp_q [3] = '{5'd7, 5'd8, 5'd10};
      issue(3'b000, 5'd5, 5'd0, 5'd0);
      issue(3'b000, 5'd6, 5'd0, 5'd0);
      issue(3'b000, 5'd7, 5'd0, 5'd0);
      issue(3'b000, 5'd8, 5'd0, 5'd0);
      dst_sel = 3'b000; instr_rd = 5'd10; issue_valid = 1'b1; wb_ready = 1'b1;
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", issue_ready); end
      tick();
      #1;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 3", count); end
      n_checks++; if (wb_addr !== 5'd6) begin n_fail++; $display("FAIL full_pop_head: got %0d expected 6", wb_addr); end
      n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_simul_ready: got %b expected 1", issue_ready); end
      tick();
      issue_valid = 1'b0; wb_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL simul_count: got %0d expected 3", count); end
      n_checks++; if (pending !== 32'h0000_0580) begin n_fail++; $display("FAIL simul_pending: got %h expected 00000580", pending); end
      wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (wb_addr !== exp_q[i]) begin n_fail++; $display("FAIL wrap_drain_%0d: got %0d expected %0d", i, wb_addr, exp_q[i]); end
         tick();
      end
      wb_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_count: got %0d expected 0", count); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL wrap_pending: got %h expected 0", pending); end
   endtask

   task automatic test_reserved_reset();
      dst_sel = 3'b110; instr_rd = 5'd7; issue_valid = 1'b1;
      #1;
      n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rsv_ready: got %b expected 0", issue_ready); end
      tick();
      issue_valid = 1'b0; dst_sel = 3'b000;
      #1;
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL rsv_sel_err: got %b expected 1", sel_err); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rsv_count: got %0d expected 0", count); end
      tick();
      n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL rsv_sticky: got %b expected 1", sel_err); end
      issue(3'b000, 5'd3, 5'd0, 5'd0);
      issue(3'b000, 5'd4, 5'd0, 5'd0);
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 2", count); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h expected 0", pending); end
      n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_sel_err: got %b expected 0", sel_err); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b expected 0", wb_valid); end
      n_checks++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL rst_wb_addr: got %0d expected 0", wb_addr); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sources();
      test_hazard();
      test_zero();
      test_full_wrap();
      test_reserved_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
